// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED pattern generator.
package led_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

    typedef logic [1:0] mode_t;

    // Clocks per blink timebase tick.
    function automatic int unsigned calc_tick_div(input int unsigned clock_hz,
                                                  input int unsigned tick_hz);
        return clock_hz / tick_hz;
    endfunction

    // Prescaler counter width able to hold 0..tick_div-1.
    function automatic int unsigned calc_presc_w(input int unsigned tick_div);
        return (tick_div > 1) ? $clog2(tick_div) : 1;
    endfunction

endpackage

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: holds its mode/value and produces a registered LED level.
module led_channel
    import led_pkg::*;
#(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned DUTY_W   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic [DUTY_W-1:0]   pwm_cnt,
    input  logic                we,
    input  mode_t               cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_value,
    output logic                led
);

    mode_t               mode;
    logic [PERIOD_W-1:0] value;
    logic [PERIOD_W-1:0] half_cnt;
    logic [PERIOD_W-1:0] half_last;

    // A half-period of zero behaves as one tick.
    assign half_last = (value == '0) ? '0 : value - PERIOD_W'(1);

    // A write takes priority over a coincident tick and restarts blink phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode     <= MODE_OFF;
            value    <= '0;
            half_cnt <= '0;
            led      <= 1'b0;
        end else if (we) begin
            mode     <= cfg_mode;
            value    <= cfg_value;
            half_cnt <= '0;
            led      <= (cfg_mode == MODE_ON) || (cfg_mode == MODE_BLINK);
        end else begin
            case (mode)
                MODE_ON:    led <= 1'b1;
                MODE_BLINK: begin
                    if (tick) begin
                        if (half_cnt == half_last) begin
                            half_cnt <= '0;
                            led      <= ~led;
                        end else begin
                            half_cnt <= half_cnt + PERIOD_W'(1);
                        end
                    end
                end
                MODE_PWM:   led <= (pwm_cnt < value[DUTY_W-1:0]);
                default:    led <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared tick prescaler and PWM counter feeding per-channel pattern logic.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter  int unsigned CLOCK_HZ = 27_000_000,
    parameter  int unsigned TICK_HZ  = 1_000,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned PERIOD_W = 16,
    parameter  int unsigned DUTY_W   = 8,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_value,
    output logic [CHANNELS-1:0] led,
    output logic                tick
);

    localparam int unsigned TICK_DIV = calc_tick_div(CLOCK_HZ, TICK_HZ);
    localparam int unsigned PRESC_W  = calc_presc_w(TICK_DIV);

    logic [PRESC_W-1:0] presc;
    logic [DUTY_W-1:0]  pwm_cnt;

    // Timebase prescaler (tick registered one cycle after terminal count) and free-running PWM counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc   <= '0;
            tick    <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
            if (presc == PRESC_W'(TICK_DIV - 1)) begin
                presc <= '0;
                tick  <= 1'b1;
            end else begin
                presc <= presc + PRESC_W'(1);
                tick  <= 1'b0;
            end
        end
    end

    // Out-of-range channel indices match no instance, so those writes vanish.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic we;
        assign we = cfg_we && (cfg_ch == CH_W'(i));

        led_channel #(
            .PERIOD_W (PERIOD_W),
            .DUTY_W   (DUTY_W)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .tick      (tick),
            .pwm_cnt   (pwm_cnt),
            .we        (we),
            .cfg_mode  (cfg_mode),
            .cfg_value (cfg_value),
            .led       (led[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: cycle-level reference model feeds an expectation queue.
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int NCH = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_value = '0;
    logic [2:0]  led;
    logic        tick;

    led_pattern_gen #(
        .CLOCK_HZ (100),
        .TICK_HZ  (10),
        .CHANNELS (NCH),
        .PERIOD_W (16),
        .DUTY_W   (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_value (cfg_value),
        .led       (led),
        .tick      (tick)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       tick;
        logic [2:0] led;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: n = rising edges since reset release; k = ticks applied since last write.
    int n;
    int m_mode[NCH];
    int m_val[NCH];
    int m_k[NCH];
    initial begin
        exp_t e;
        bit   tick_prev;
        bit   wrote;
        int   eff;
        n = 0;
        forever begin
            @(posedge clock);
            if (reset) begin
                n = 0;
                for (int c = 0; c < NCH; c++) begin
                    m_mode[c] = 0;
                    m_val[c]  = 0;
                    m_k[c]    = 0;
                end
            end else begin
                n = n + 1;
                tick_prev = ((n - 1) > 0) && (((n - 1) % 10) == 0);
                e.tick = ((n % 10) == 0);
                e.led  = '0;
                for (int c = 0; c < NCH; c++) begin
                    wrote = cfg_we && (int'(cfg_ch) == c);
                    if (wrote) begin
                        m_mode[c] = int'(cfg_mode);
                        m_val[c]  = int'(cfg_value);
                        m_k[c]    = 0;
                    end else if (tick_prev) begin
                        m_k[c] = m_k[c] + 1;
                    end
                    case (m_mode[c])
                        1: e.led[c] = 1'b1;
                        2: begin
                            eff = (m_val[c] == 0) ? 1 : m_val[c];
                            e.led[c] = (((m_k[c] / eff) % 2) == 0);
                        end
                        3: e.led[c] = !wrote && (((n - 1) % 256) < (m_val[c] % 256));
                        default: e.led[c] = 1'b0;
                    endcase
                end
                exp_q.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: negedge compares against the queue; a reset rise between edges checks the async clear.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock or posedge reset);
            if (($time % 10) != 0) begin
                #1;
                chk("async_reset_led", {1'b0, led}, 4'b0000);
            end else if (reset) begin
                exp_q.delete();
                chk("reset_state", {tick, led}, 4'b0000);
            end else if (exp_q.size() == 0) begin
                chk("missing_expectation", {tick, led}, 4'bxxxx);
            end else begin
                e = exp_q.pop_front();
                chk("tick", {3'b000, tick}, {3'b000, e.tick});
                chk("led", {1'b0, led}, {1'b0, e.led});
            end
        end
    end

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clock);
    endtask

    task automatic wr_now(input int ch, input logic [1:0] md, input int v);
        cfg_we    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_mode  = md;
        cfg_value = 16'(v);
        @(negedge clock);
        cfg_we    = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [1:0] md, input int v);
        @(negedge clock);
        wr_now(ch, md, v);
    endtask

    // Stimulus: directed scenarios, then randomized config traffic.
    initial begin
        int r;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        idle(25);

        wr(0, MODE_BLINK, 3);
        idle(130);

        wr(1, MODE_PWM, 64);
        idle(520);
        wr(1, MODE_PWM, 0);
        idle(260);
        wr(1, MODE_PWM, 255);
        idle(520);

        // Land a ch2 write on the same edge that consumes a tick.
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tick) break;
        end
        wr_now(2, MODE_BLINK, 0);
        idle(60);

        @(posedge clock);
        #2 reset = 1'b1;
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        idle(40);

        wr(3, MODE_ON, 0);
        idle(5);
        wr(0, MODE_ON, 0);
        idle(5);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            cfg_we   = ($urandom_range(0, 39) == 0);
            cfg_ch   = 2'($urandom_range(0, 3));
            cfg_mode = 2'($urandom_range(0, 3));
            if (cfg_mode == MODE_PWM) begin
                r = int'($urandom_range(0, 9));
                cfg_value[7:0]  = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
                cfg_value[15:8] = 8'($urandom);
            end else begin
                cfg_value = 16'($urandom_range(0, 4));
            end
        end
        @(negedge clock);
        cfg_we = 1'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
